// File: rtl/rng_arb_pkg.sv
// Shared types and sizing helpers for the RNG request arbiter.
// Holds the FSM state enum, the counter width and the index-width function.
package rng_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE,
      ERR
   } arb_state_e;

   localparam int N_DEF   = 4;
   localparam int W_DEF   = 8;
   localparam int LAT_DEF = 1;
   localparam int LAT_MAX = 4;

   // Wait counter must hold RNG_LATENCY up to LAT_MAX.
   localparam int CNT_W = $clog2(LAT_MAX + 1);

   // Index width with a floor of one bit.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int IDX_W = idx_w(N_DEF);

endpackage

// File: rtl/rng_request_arbiter_if.sv
// Bus between the arbiter, its N requesters and the RandomGenerator.
// master: arbiter side; slave: requesters plus generator side.
interface rng_request_arbiter_if #(
   parameter int N = 4,
   parameter int W = 8
);

   logic [N-1:0]   in_req;
   logic [N*W-1:0] in_min;
   logic [N*W-1:0] in_max;
   logic [N-1:0]   out_ack;
   logic [W-1:0]   out_rnd;
   logic           out_range_err;

   logic           out_rng_enable;
   logic [W-1:0]   out_rng_min;
   logic [W-1:0]   out_rng_max;
   logic [W-1:0]   in_rng_value;

   modport master (
      input  in_req,
      input  in_min,
      input  in_max,
      output out_ack,
      output out_rnd,
      output out_range_err,
      output out_rng_enable,
      output out_rng_min,
      output out_rng_max,
      input  in_rng_value
   );

   modport slave (
      output in_req,
      output in_min,
      output in_max,
      input  out_ack,
      input  out_rnd,
      input  out_range_err,
      input  out_rng_enable,
      input  out_rng_min,
      input  out_rng_max,
      output in_rng_value
   );

endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin priority search: first set req bit at or after rr_ptr, wrapping.
// Ports: req, rr_ptr in; found flag and selected idx out (combinational).
module rr_priority_picker #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] rr_ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   always_comb begin
      int j;
      found = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/rng_request_arbiter.sv
// Shares one RandomGenerator among N range requesters, round-robin.
// Ports: in_clock, in_reset (sync, active high), bus (master modport).
module rng_request_arbiter
   import rng_arb_pkg::*;
#(
   parameter int N           = N_DEF,
   parameter int W           = W_DEF,
   parameter int RNG_LATENCY = LAT_DEF
) (
   input logic                 in_clock,
   input logic                 in_reset,
   rng_request_arbiter_if.master bus
);

   localparam int IW = idx_w(N);

   arb_state_e     state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [IW-1:0]  ptr_q, ptr_d;
   logic [W-1:0]   min_q, min_d;
   logic [W-1:0]   max_q, max_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]   ack_q, ack_d;
   logic [W-1:0]   rnd_q, rnd_d;
   logic           err_q, err_d;
   logic           en_q, en_d;

   logic           pick_found;
   logic [IW-1:0]  pick_idx;
   logic [W-1:0]   sel_min;
   logic [W-1:0]   sel_max;

   rr_priority_picker #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req    (bus.in_req),
      .rr_ptr (ptr_q),
      .found  (pick_found),
      .idx    (pick_idx)
   );

   always_comb begin
      sel_min = bus.in_min[pick_idx*W +: W];
      sel_max = bus.in_max[pick_idx*W +: W];
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      min_d   = min_q;
      max_d   = max_q;
      cnt_d   = cnt_q;
      ack_d   = '0;
      rnd_d   = '0;
      err_d   = 1'b0;
      en_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               idx_d = pick_idx;
               min_d = sel_min;
               max_d = sel_max;
               if ($signed(sel_min) > $signed(sel_max)) begin
                  state_d = ERR;
                  // Error path returns the lower bound as the result.
                  rnd_d   = sel_min;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_d   = CNT_W'(RNG_LATENCY);
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               rnd_d   = bus.in_rng_value;
               state_d = DONE;
            end
         end
         DONE, ERR: begin
            if (idx_q == IW'(N - 1)) ptr_d = '0;
            else                     ptr_d = idx_q + IW'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so decode them from the next state.
      en_d  = (state_d == ISSUE);
      err_d = (state_d == ERR);
      if (state_d == DONE || state_d == ERR) ack_d[idx_d] = 1'b1;
   end

   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
         min_q   <= '0;
         max_q   <= '0;
         cnt_q   <= '0;
         ack_q   <= '0;
         rnd_q   <= '0;
         err_q   <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         min_q   <= min_d;
         max_q   <= max_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         rnd_q   <= rnd_d;
         err_q   <= err_d;
         en_q    <= en_d;
      end
   end

   assign bus.out_ack        = ack_q;
   assign bus.out_rnd        = rnd_q;
   assign bus.out_range_err  = err_q;
   assign bus.out_rng_enable = en_q;
   assign bus.out_rng_min    = min_q;
   assign bus.out_rng_max    = max_q;

endmodule

// File: tb/tb_rng_request_arbiter.sv
// Directed bench for rng_request_arbiter: latency-1 and latency-3 instances.
// Checks reset, round robin, range error, degenerate range, reset abort, drop.
module tb_rng_request_arbiter;

   logic clk;
   logic rst;
   logic [7:0] stub_val;
   int checks = 0;
   int errors = 0;

   rng_request_arbiter_if #(.N(4), .W(8)) bus ();
   rng_request_arbiter_if #(.N(4), .W(8)) bus3 ();

   rng_request_arbiter #(.N(4), .W(8), .RNG_LATENCY(1)) dut (
      .in_clock (clk),
      .in_reset (rst),
      .bus      (bus)
   );

   rng_request_arbiter #(.N(4), .W(8), .RNG_LATENCY(3)) dut3 (
      .in_clock (clk),
      .in_reset (rst),
      .bus      (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Generator stub: value appears one cycle after enable.
   always @(posedge clk) begin
      if (rst) bus.in_rng_value <= 8'h00;
      else if (bus.out_rng_enable) bus.in_rng_value <= stub_val;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      stub_val = 8'h00;
      bus.in_req = '0;
      bus.in_min = '0;
      bus.in_max = '0;
      bus3.in_req = '0;
      bus3.in_min = '0;
      bus3.in_max = '0;
      bus3.in_rng_value = '0;
      tick();
      tick();
      chk("rst_ack", 16'(bus.out_ack), 16'h0);
      chk("rst_rnd", 16'(bus.out_rnd), 16'h0);
      chk("rst_err", 16'(bus.out_range_err), 16'h0);
      chk("rst_en", 16'(bus.out_rng_enable), 16'h0);
      chk("rst_min", 16'(bus.out_rng_min), 16'h0);
      chk("rst_max", 16'(bus.out_rng_max), 16'h0);
      chk("rst_ack3", 16'(bus3.out_ack), 16'h0);
      rst = 1'b0;

      // All four requesters at once, rr_ptr = 0.
      for (int i = 0; i < 4; i++) begin
         bus.in_min[i*8 +: 8] = 8'd0;
         bus.in_max[i*8 +: 8] = 8'd10;
      end
      stub_val = 8'h33;
      bus.in_req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         tick();
         tick();
         chk("rr_gap", 16'(bus.out_ack), 16'h0);
         tick();
         chk("rr_ack", 16'(bus.out_ack), 16'(4'b0001 << k));
         chk("rr_rnd", 16'(bus.out_rnd), 16'h33);
         bus.in_req[k] = 1'b0;
         tick();
      end

      // Pointer wrapped to 0: req[0] wins over req[1].
      bus.in_req = 4'b0011;
      tick();
      tick();
      tick();
      chk("wrap_first", 16'(bus.out_ack), 16'h1);
      bus.in_req = 4'b0010;
      tick();
      tick();
      tick();
      tick();
      chk("wrap_second", 16'(bus.out_ack), 16'h2);
      bus.in_req = '0;
      tick();

      // Single request on req[2], range -20..2.
      bus.in_min[16 +: 8] = 8'hEC;
      bus.in_max[16 +: 8] = 8'h02;
      stub_val = 8'h05;
      bus.in_req = 4'b0100;
      tick();
      chk("one_en", 16'(bus.out_rng_enable), 16'h1);
      chk("one_rmin", 16'(bus.out_rng_min), 16'hEC);
      chk("one_rmax", 16'(bus.out_rng_max), 16'h02);
      chk("one_ack_early", 16'(bus.out_ack), 16'h0);
      tick();
      chk("one_en_off", 16'(bus.out_rng_enable), 16'h0);
      chk("one_rmin_hold", 16'(bus.out_rng_min), 16'hEC);
      tick();
      chk("one_ack", 16'(bus.out_ack), 16'h4);
      chk("one_rnd", 16'(bus.out_rnd), 16'h05);
      chk("one_err", 16'(bus.out_range_err), 16'h0);
      bus.in_req = '0;
      tick();
      chk("one_ack_once", 16'(bus.out_ack), 16'h0);

      // Range error on req[1]: min 20 > max 10.
      bus.in_min[8 +: 8] = 8'd20;
      bus.in_max[8 +: 8] = 8'd10;
      bus.in_req = 4'b0010;
      tick();
      chk("err_ack", 16'(bus.out_ack), 16'h2);
      chk("err_flag", 16'(bus.out_range_err), 16'h1);
      chk("err_rnd", 16'(bus.out_rnd), 16'h14);
      chk("err_en", 16'(bus.out_rng_enable), 16'h0);
      bus.in_req = '0;
      tick();
      chk("err_ack_off", 16'(bus.out_ack), 16'h0);
      chk("err_flag_off", 16'(bus.out_range_err), 16'h0);
      chk("err_en_off", 16'(bus.out_rng_enable), 16'h0);

      // Degenerate range on req[3]: min == max == -7.
      bus.in_min[24 +: 8] = 8'hF9;
      bus.in_max[24 +: 8] = 8'hF9;
      stub_val = 8'hF9;
      bus.in_req = 4'b1000;
      tick();
      chk("deg_en", 16'(bus.out_rng_enable), 16'h1);
      chk("deg_rmax", 16'(bus.out_rng_max), 16'hF9);
      tick();
      tick();
      chk("deg_ack", 16'(bus.out_ack), 16'h8);
      chk("deg_rnd", 16'(bus.out_rnd), 16'hF9);
      chk("deg_err", 16'(bus.out_range_err), 16'h0);
      bus.in_req = '0;
      tick();

      // Reset while in WAIT aborts with no ack.
      stub_val = 8'h77;
      bus.in_req = 4'b0100;
      tick();
      chk("abort_en", 16'(bus.out_rng_enable), 16'h1);
      tick();
      rst = 1'b1;
      bus.in_req = '0;
      tick();
      chk("abort_ack", 16'(bus.out_ack), 16'h0);
      chk("abort_en0", 16'(bus.out_rng_enable), 16'h0);
      chk("abort_rnd", 16'(bus.out_rnd), 16'h0);
      chk("abort_err", 16'(bus.out_range_err), 16'h0);
      chk("abort_rmin", 16'(bus.out_rng_min), 16'h0);
      chk("abort_rmax", 16'(bus.out_rng_max), 16'h0);
      rst = 1'b0;
      bus.in_req = 4'b1000;
      tick();
      tick();
      tick();
      chk("post_rst_ack", 16'(bus.out_ack), 16'h8);
      chk("post_rst_rnd", 16'(bus.out_rnd), 16'h77);
      bus.in_req = '0;
      tick();

      // Latency 3 with the request dropped after one cycle.
      bus3.in_min[0 +: 8] = 8'd0;
      bus3.in_max[0 +: 8] = 8'd100;
      bus3.in_req = 4'b0001;
      tick();
      bus3.in_req = '0;
      chk("lat_en", 16'(bus3.out_rng_enable), 16'h1);
      tick();
      chk("lat_en_off", 16'(bus3.out_rng_enable), 16'h0);
      chk("lat_ack_t2", 16'(bus3.out_ack), 16'h0);
      bus3.in_rng_value = 8'h11;
      tick();
      bus3.in_rng_value = 8'h22;
      tick();
      chk("lat_ack_t4", 16'(bus3.out_ack), 16'h0);
      bus3.in_rng_value = 8'h33;
      tick();
      chk("lat_ack", 16'(bus3.out_ack), 16'h1);
      chk("lat_rnd", 16'(bus3.out_rnd), 16'h33);
      chk("lat_err", 16'(bus3.out_range_err), 16'h0);
      bus3.in_rng_value = 8'h44;
      tick();
      chk("lat_ack_once", 16'(bus3.out_ack), 16'h0);
      tick();
      tick();
      chk("lat_no_rearm", 16'(bus3.out_rng_enable), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rng_request_arbiter.md
# rng_request_arbiter

Shares one RandomGenerator instance among N constraint-variable requesters in the MCMC solver. Each requester asks for a signed value in its own [min, max] range. The arbiter picks one requester round-robin and drives the generator's enable and range inputs for that request. It then captures the result and returns it with a one-cycle acknowledge. It sits between the variable-update logic and the single RandomGenerator.

## Interface
- N, 4, number of requesters (2..16)
- W, 8, data width of min/max/random value (signed)
- RNG_LATENCY, 1, cycles from the enable edge until the RandomGenerator output is valid (1..4)
- in_clock  input  1  single clock, rising edge
- in_reset  input  1  synchronous, active-high reset
- in_req  input  N  per-requester request level
- in_min  input  N*W  packed signed lower bounds; requester i at [i*W +: W]
- in_max  input  N*W  packed signed upper bounds, same packing
- out_ack  output  N  one-hot, high for exactly one cycle when the request completes
- out_rnd  output  W  signed result; valid only in the out_ack cycle
- out_range_err  output  1  high with out_ack when the served request had min > max
- out_rng_enable  output  1  enable to RandomGenerator in_enable
- out_rng_min  output  W  to RandomGenerator in_min
- out_rng_max  output  W  to RandomGenerator in_max
- in_rng_value  input  W  from RandomGenerator out_rnd

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE, any in_req set:
  - Select the first set bit at or after rr_ptr, wrapping modulo N.
  - Latch the index and that requester's min/max.
  - Compare min and max as signed values. If min > max, go to ERR; otherwise go to ISSUE.
- ISSUE:
  - out_rng_enable=1 for this single cycle; out_rng_min/max = latched values.
  - Load wait counter with RNG_LATENCY. Go to WAIT.
- WAIT:
  - out_rng_enable=0. out_rng_min/max hold the latched values until DONE ends.
  - Decrement the counter each cycle. In the cycle the counter equals 1, register in_rng_value into the result. Go to DONE.
- DONE:
  - out_ack[idx]=1, out_rnd=result, out_range_err=0.
  - rr_ptr = (idx+1) mod N. Go to IDLE.
- ERR:
  - out_ack[idx]=1, out_range_err=1, out_rnd=latched min. The RandomGenerator is not touched.
  - rr_ptr = (idx+1) mod N. Go to IDLE.
- min == max is a valid range and goes through ISSUE/WAIT/DONE normally.
- Requester protocol:
  - Hold in_req, in_min and in_max stable until it sees out_ack.
  - Clear in_req on the clock edge at which its out_ack is high.
  - in_req still high in the following IDLE cycle is treated as a new request.
- Request dropped mid-transaction: the arbiter still completes the transaction and pulses out_ack. in_req is not re-sampled after IDLE.
- in_min/in_max changes after latching are ignored.
- Only one transaction is in flight at a time; no pipelining.

## Timing
- Request sampled in IDLE at cycle t:
  - ISSUE at t+1.
  - WAIT from t+2 to t+1+RNG_LATENCY.
  - DONE/out_ack at t+2+RNG_LATENCY. This is t+3 for the default.
- Range-error request sampled at t: ERR/out_ack at t+1.
- Back-to-back throughput: one grant per 3+RNG_LATENCY cycles, since IDLE takes one cycle between transactions.
- Reset values, and values on any cycle with in_reset=1:
  - state=IDLE, rr_ptr=0.
  - out_ack=0, out_rnd=0, out_range_err=0.
  - out_rng_enable=0, out_rng_min=0, out_rng_max=0.
- Reset mid-transaction aborts it with no ack. The RandomGenerator shares in_reset.
- All outputs are registered except out_rng_min/max, which come straight from the latch registers.

## Structure
- Package rng_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE, ERR);
  - IDX_W = $clog2(N) (minimum 1) and the counter-width constant.
- One sub-module, rr_priority_picker: combinational. Inputs are N-bit req and rr_ptr; outputs are a found flag and the selected index.
- Everything else is one FSM plus the datapath registers in rng_request_arbiter.

## Test plan
- Single request: N=4, W=8, RNG stub returns 5 one cycle after enable.
  - Stimulus: req[2] with min=-20, max=2 at cycle t.
  - Expected: out_rng_enable only at t+1 with min/max -20/2; out_ack=0100 and out_rnd=5 at t+3; no other ack.
- All four requests together, rr_ptr=0, each held until ack:
  - Expected: acks in order 0,1,2,3, spaced 4 cycles apart.
  - Then re-raise req[1] and req[0] together: req[1] served first only if rr_ptr=1. Check rr_ptr=0 after index 3, so req[0] is served first.
- Range error: req[1] with min=20, max=10.
  - Expected: out_ack=0010, out_range_err=1, out_rnd=20 at t+1; out_rng_enable stays 0 throughout.
- Degenerate range: min=max=-7 with the stub returning -7.
  - Expected: normal DONE path; out_rnd=-7, out_range_err=0.
- Reset during WAIT: assert in_reset for one cycle at t+2.
  - Expected: no ack; all outputs 0 the cycle after reset.
  - A fresh req[3] is then served first because rr_ptr=0 selects the lowest pending requester.
- Drop and latency: req[0] deasserted at t+1, and RNG_LATENCY=3.
  - Expected: ack still pulses at t+5; in_rng_value is captured from cycle t+4 only.
